// File: rtl/pong_ball_engine.sv
// Pong ball engine: advances the ball once per game tick, resolves wall and paddle
// collisions, flags scoring and sequences idle/serve/play/point.
module pong_ball_engine #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned BALL_SIZE   = 8,
    parameter int unsigned PADDLE_W    = 8,
    parameter int unsigned PADDLE_H    = 64,
    parameter int unsigned PADDLE_LX   = 16,
    parameter int unsigned PADDLE_RX   = 616,
    parameter int unsigned STEP        = 2,
    parameter int unsigned SERVE_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_clk,
    input  logic       start,
    input  logic       pause,
    input  logic [9:0] paddle_l_y,
    input  logic [9:0] paddle_r_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       score_l,
    output logic       score_r,
    output logic [1:0] state
);

    localparam logic [9:0]  CX        = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0]  CY        = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [10:0] XMAX      = 11'(H_RES - BALL_SIZE);
    localparam logic [10:0] YMAX      = 11'(V_RES - BALL_SIZE);
    localparam logic [10:0] STEP_W    = 11'(STEP);
    localparam logic [10:0] BALL_W    = 11'(BALL_SIZE);
    localparam logic [10:0] PAD_H_W   = 11'(PADDLE_H);
    localparam logic [10:0] FACE_L    = 11'(PADDLE_LX + PADDLE_W);
    localparam logic [10:0] FACE_R    = 11'(PADDLE_RX);
    localparam logic [9:0]  HIT_L_X   = 10'(PADDLE_LX + PADDLE_W);
    localparam logic [9:0]  HIT_R_X   = 10'(PADDLE_RX - BALL_SIZE);
    localparam int unsigned CntW      = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS + 1) : 1;
    localparam logic [CntW-1:0] SERVE_LAST = CntW'(SERVE_TICKS - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StServe = 2'b01,
        StPlay  = 2'b10,
        StPoint = 2'b11
    } state_e;

    state_e          state_q, state_d;
    logic [9:0]      x_q, x_d, y_q, y_d;
    logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic            score_l_q, score_l_d, score_r_q, score_r_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            s1_q, s2_q, p_q;
    logic            tick;

    // game_clk is only ever data here: synchronise, then take its rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            p_q  <= 1'b0;
        end else begin
            s1_q <= game_clk;
            s2_q <= s1_q;
            p_q  <= s2_q;
        end
    end

    assign tick = s2_q & ~p_q;

    logic [10:0] x_ext, y_ext, pl_ext, pr_ext;
    logic [10:0] x_fwd, x_back, y_fwd, y_back;
    logic        overlap_l, overlap_r, hit_l, hit_r;
    logic [9:0]  x_play, y_play;
    logic        dir_x_play, dir_y_play, wall_l, wall_r;

    assign x_ext  = {1'b0, x_q};
    assign y_ext  = {1'b0, y_q};
    assign pl_ext = {1'b0, paddle_l_y};
    assign pr_ext = {1'b0, paddle_r_y};

    // Candidate play-step: both axes derived from the pre-update position.
    always_comb begin
        x_fwd      = (x_ext + STEP_W > XMAX) ? XMAX : x_ext + STEP_W;
        x_back     = (x_ext < STEP_W) ? '0 : x_ext - STEP_W;
        y_fwd      = (y_ext + STEP_W > YMAX) ? YMAX : y_ext + STEP_W;
        y_back     = (y_ext < STEP_W) ? '0 : y_ext - STEP_W;
        overlap_l  = (y_ext + BALL_W > pl_ext) && (y_ext < pl_ext + PAD_H_W);
        overlap_r  = (y_ext + BALL_W > pr_ext) && (y_ext < pr_ext + PAD_H_W);
        hit_l      = (x_ext >= FACE_L) && (x_back <= FACE_L) && overlap_l;
        hit_r      = (x_ext + BALL_W <= FACE_R) && (x_fwd + BALL_W >= FACE_R) && overlap_r;
        wall_l     = 1'b0;
        wall_r     = 1'b0;
        x_play     = x_q;
        dir_x_play = dir_x_q;

        if (dir_y_q) begin
            y_play     = 10'(y_fwd);
            dir_y_play = (y_fwd != YMAX);
        end else begin
            y_play     = 10'(y_back);
            dir_y_play = (y_back == '0);
        end

        if (dir_x_q) begin
            if (hit_r) begin
                x_play     = HIT_R_X;
                dir_x_play = 1'b0;
            end else begin
                x_play     = 10'(x_fwd);
                dir_x_play = 1'b1;
                wall_r     = (x_fwd == XMAX);
            end
        end else begin
            if (hit_l) begin
                x_play     = HIT_L_X;
                dir_x_play = 1'b1;
            end else begin
                x_play     = 10'(x_back);
                dir_x_play = 1'b0;
                wall_l     = (x_back == '0);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        cnt_d     = cnt_q;
        score_l_d = 1'b0;
        score_r_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                x_d = CX;
                y_d = CY;
                if (start) begin
                    state_d = StServe;
                    cnt_d   = '0;
                end
            end
            StServe: begin
                x_d = CX;
                y_d = CY;
                if (tick && !pause) begin
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == SERVE_LAST) begin
                        state_d = StPlay;
                    end
                end
            end
            StPlay: begin
                if (tick && !pause) begin
                    x_d     = x_play;
                    y_d     = y_play;
                    dir_x_d = dir_x_play;
                    dir_y_d = dir_y_play;
                    if (wall_r) begin
                        score_l_d = 1'b1;
                        state_d   = StPoint;
                    end else if (wall_l) begin
                        score_r_d = 1'b1;
                        state_d   = StPoint;
                    end
                end
            end
            StPoint: begin
                if (tick) begin
                    state_d = StServe;
                    cnt_d   = '0;
                    x_d     = CX;
                    y_d     = CY;
                    // The frozen ball sits on the wall that was reached, which names the scorer.
                    dir_x_d = ({1'b0, x_q} == XMAX);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            x_q       <= CX;
            y_q       <= CY;
            dir_x_q   <= 1'b1;
            dir_y_q   <= 1'b1;
            cnt_q     <= '0;
            score_l_q <= 1'b0;
            score_r_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            cnt_q     <= cnt_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
        end
    end

    assign ball_x  = x_q;
    assign ball_y  = y_q;
    assign dir_x   = dir_x_q;
    assign dir_y   = dir_y_q;
    assign score_l = score_l_q;
    assign score_r = score_r_q;
    assign state   = state_q;

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: a STEP=2 and a STEP=3 instance share stimulus; a game model
// feeds a per-tick scoreboard, and a vector table pins hand-derived checkpoints.
module tb_pong_ball_engine;

    localparam int CXI = 316, CYI = 236, XMAXI = 632, YMAXI = 472;
    localparam int FLI = 24, PRXI = 616, BALLI = 8, PHI = 64, SERVE_T = 2;

    logic       clk = 1'b0, rst = 1'b1, game_clk = 1'b0, start = 1'b0, pause = 1'b0;
    logic [9:0] paddle_l_y = '0, paddle_r_y = '0;
    logic [9:0] a_x, a_y, b_x, b_y;
    logic       a_dx, a_dy, a_sl, a_sr, b_dx, b_dy, b_sl, b_sr;
    logic [1:0] a_st, b_st;

    always #5 clk = ~clk;

    pong_ball_engine #(.STEP(2), .SERVE_TICKS(2)) dut_a (
        .clk(clk), .rst(rst), .game_clk(game_clk), .start(start), .pause(pause),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(a_x), .ball_y(a_y), .dir_x(a_dx), .dir_y(a_dy),
        .score_l(a_sl), .score_r(a_sr), .state(a_st)
    );

    pong_ball_engine #(.STEP(3), .SERVE_TICKS(2)) dut_b (
        .clk(clk), .rst(rst), .game_clk(game_clk), .start(start), .pause(pause),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
        .ball_x(b_x), .ball_y(b_y), .dir_x(b_dx), .dir_y(b_dy),
        .score_l(b_sl), .score_r(b_sr), .state(b_st)
    );

    typedef struct {
        int x, y, dx, dy, st, cnt, sl, sr, last_l;
    } mstate_t;

    typedef struct {
        bit do_rst;
        bit pse;
        int pl, pr, n;
        int ex, ey, edx, edy, est;
        bit bchk;
        int by, bdy;
    } vec_t;

    mstate_t m_a, m_b, rst_m;
    mstate_t q_a[$], q_b[$];
    vec_t    vecs[11];
    int      n_chk = 0, n_pass = 0;

    function automatic mstate_t model_tick(mstate_t s, int step, int pl, int pr, bit pse);
        mstate_t n = s;
        int xn, yn;
        n.sl = 0;
        n.sr = 0;
        case (s.st)
            1: if (!pse) begin
                n.cnt = s.cnt + 1;
                if (n.cnt == SERVE_T) n.st = 2;
            end
            2: if (!pse) begin
                if (s.dy != 0) begin
                    yn = s.y + step;
                    if (yn >= YMAXI) begin yn = YMAXI; n.dy = 0; end
                end else begin
                    yn = s.y - step;
                    if (yn <= 0) begin yn = 0; n.dy = 1; end
                end
                n.y = yn;
                if (s.dx != 0) begin
                    xn = (s.x + step > XMAXI) ? XMAXI : s.x + step;
                    if (s.x + BALLI <= PRXI && xn + BALLI >= PRXI &&
                        s.y + BALLI > pr && s.y < pr + PHI) begin
                        n.x = PRXI - BALLI; n.dx = 0;
                    end else begin
                        n.x = xn;
                        if (xn == XMAXI) begin n.sl = 1; n.st = 3; n.last_l = 1; end
                    end
                end else begin
                    xn = (s.x - step < 0) ? 0 : s.x - step;
                    if (s.x >= FLI && xn <= FLI && s.y + BALLI > pl && s.y < pl + PHI) begin
                        n.x = FLI; n.dx = 1;
                    end else begin
                        n.x = xn;
                        if (xn == 0) begin n.sr = 1; n.st = 3; n.last_l = 0; end
                    end
                end
            end
            3: begin
                n.st = 1; n.cnt = 0; n.x = CXI; n.y = CYI; n.dx = s.last_l;
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [31:0] pack_m(mstate_t s);
        return {6'd0, 10'(s.x), 10'(s.y), 1'(s.dx), 1'(s.dy), 1'(s.sl), 1'(s.sr), 2'(s.st)};
    endfunction

    function automatic logic [31:0] pack_a();
        return {6'd0, a_x, a_y, a_dx, a_dy, a_sl, a_sr, a_st};
    endfunction

    function automatic logic [31:0] pack_b();
        return {6'd0, b_x, b_y, b_dx, b_dy, b_sl, b_sr, b_st};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic do_tick();
        mstate_t pre, e_a, e_b;
        pre = m_a;
        @(negedge clk);
        game_clk = 1'b1;
        m_a = model_tick(m_a, 2, int'(paddle_l_y), int'(paddle_r_y), pause);
        m_b = model_tick(m_b, 3, int'(paddle_l_y), int'(paddle_r_y), pause);
        q_a.push_back(m_a);
        q_b.push_back(m_b);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("pre_update_a", pack_a(), pack_m(pre));
        @(posedge clk);
        #1;
        e_a = q_a.pop_front();
        e_b = q_b.pop_front();
        check("tick_a", pack_a(), pack_m(e_a));
        check("tick_b", pack_b(), pack_m(e_b));
        @(posedge clk);
        #1;
        e_a.sl = 0; e_a.sr = 0; e_b.sl = 0; e_b.sr = 0;
        check("pulse_end_a", pack_a(), pack_m(e_a));
        check("pulse_end_b", pack_b(), pack_m(e_b));
        m_a.sl = 0; m_a.sr = 0; m_b.sl = 0; m_b.sr = 0;
        @(negedge clk);
        game_clk = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("fall_edge_a", pack_a(), pack_m(e_a));
        check("fall_edge_b", pack_b(), pack_m(e_b));
    endtask

    task automatic game_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset_a", pack_a(), pack_m(rst_m));
        check("async_reset_b", pack_b(), pack_m(rst_m));
        @(negedge clk);
        rst = 1'b0;
        m_a = rst_m;
        m_b = rst_m;
        q_a.delete();
        q_b.delete();
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        if (m_a.st == 0) begin m_a.st = 1; m_a.cnt = 0; end
        if (m_b.st == 0) begin m_b.st = 1; m_b.cnt = 0; end
        @(negedge clk);
        start = 1'b0;
        check("start_a", {30'd0, a_st}, {30'd0, 2'(m_a.st)});
    endtask

    initial begin
        rst_m = '{x: CXI, y: CYI, dx: 1, dy: 1, st: 0, cnt: 0, sl: 0, sr: 0, last_l: 1};
        m_a = rst_m;
        m_b = rst_m;
        //          rst  pse  pl   pr   n    x    y    dx dy st bchk by bdy
        vecs[0]  = '{1'b1, 1'b0, 140, 400, 118, 552, 472, 1, 0, 2, 1'b0, 0, 0};
        vecs[1]  = '{1'b0, 1'b0, 140, 400, 28,  608, 416, 0, 0, 2, 1'b0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 140, 400, 91,  426, 234, 0, 0, 2, 1'b1, 0, 1};
        vecs[3]  = '{1'b0, 1'b0, 140, 400, 201, 24,  168, 1, 1, 2, 1'b0, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 140, 0,   146, 608, 416, 1, 0, 2, 1'b0, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 140, 0,   12,  632, 392, 1, 0, 3, 1'b0, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 140, 0,   1,   316, 236, 1, 0, 1, 1'b0, 0, 0};
        vecs[7]  = '{1'b0, 1'b1, 140, 0,   5,   316, 236, 1, 0, 1, 1'b0, 0, 0};
        vecs[8]  = '{1'b0, 1'b0, 140, 0,   2,   316, 236, 1, 0, 2, 1'b0, 0, 0};
        vecs[9]  = '{1'b0, 1'b1, 140, 0,   5,   316, 236, 1, 0, 2, 1'b0, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 140, 0,   1,   318, 234, 1, 0, 2, 1'b0, 0, 0};

        repeat (2) @(posedge clk);
        #1;
        check("power_on_reset_a", pack_a(), pack_m(rst_m));
        check("power_on_reset_b", pack_b(), pack_m(rst_m));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            paddle_l_y = 10'(vecs[i].pl);
            paddle_r_y = 10'(vecs[i].pr);
            pause      = 1'b0;
            if (vecs[i].do_rst) begin
                game_reset();
                do_tick();
                check("idle_hold_a", {30'd0, a_st}, 32'd0);
                do_start();
                do_tick();
                do_tick();
            end
            pause = vecs[i].pse;
            repeat (vecs[i].n) do_tick();
            check($sformatf("row%0d_a", i), pack_a(),
                  {6'd0, 10'(vecs[i].ex), 10'(vecs[i].ey), 1'(vecs[i].edx), 1'(vecs[i].edy),
                   2'b00, 2'(vecs[i].est)});
            if (vecs[i].bchk) begin
                check($sformatf("row%0d_b_top_clamp", i), {30'd0, b_y == 10'd0, b_dy},
                      {30'd0, vecs[i].by == 0, 1'(vecs[i].bdy)});
            end
        end

        pause = 1'b0;
        do_start();
        check("start_in_play_a", {30'd0, a_st}, 32'd2);
        do_tick();
        check("after_start_tick_a", {22'd0, a_x}, 32'd320);

        game_reset();
        do_tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
